// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin arbiter in front of one shared 64-bit ALU
// (add/sub/and/xor). Holds a single registered result plus flags under a
// valid/ready handshake and maintains the architectural ZF/SF/OF register.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. Requester ready depends on the slot state, on rsp_ready and on the
// other requester's valid. A response stays stable while valid & !ready.
module alu_share_ctrl #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_op,
  input  logic         req0_setcc,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_op,
  input  logic         req1_setcc,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic         rsp_zf,
  output logic         rsp_sf,
  output logic         rsp_of,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  logic [0:0]   state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic         rsp_id_q, rsp_id_d;
  logic [W-1:0] rsp_result_q, rsp_result_d;
  logic         rsp_zf_q, rsp_zf_d;
  logic         rsp_sf_q, rsp_sf_d;
  logic         rsp_of_q, rsp_of_d;
  logic         cc_zf_q, cc_zf_d;
  logic         cc_sf_q, cc_sf_d;
  logic         cc_of_q, cc_of_d;

  logic         slot_free;
  logic         sel1;
  logic         accept;
  logic [1:0]   op;
  logic         setcc;
  logic [W-1:0] opa, opb;
  logic [W-1:0] alu_r;
  logic         alu_of;

  // Arbitration: a lone requester wins; on contention the one not granted last wins.
  always_comb begin
    slot_free  = (state_q == ST_EMPTY) | rsp_ready;
    sel1       = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    // Ready is suppressed during reset so nothing presented then is taken.
    req0_ready = slot_free & req0_valid & ~sel1 & ~rst;
    req1_ready = slot_free & req1_valid & sel1 & ~rst;
    accept     = req0_ready | req1_ready;
    op         = sel1 ? req1_op    : req0_op;
    setcc      = sel1 ? req1_setcc : req0_setcc;
    opa        = sel1 ? req1_a     : req0_a;
    opb        = sel1 ? req1_b     : req0_b;
  end

  // Shared ALU on the granted operands, including signed-overflow flag.
  always_comb begin
    alu_r  = '0;
    alu_of = 1'b0;
    case (op)
      OP_ADD: begin
        alu_r  = opa + opb;
        alu_of = (opa[W-1] == opb[W-1]) & (alu_r[W-1] != opa[W-1]);
      end
      OP_SUB: begin
        alu_r  = opa - opb;
        alu_of = (opa[W-1] != opb[W-1]) & (alu_r[W-1] != opa[W-1]);
      end
      OP_AND:  alu_r = opa & opb;
      default: alu_r = opa ^ opb;
    endcase
  end

  // Next-state: slot FSM, response capture, CC update and round-robin pointer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zf_d     = rsp_zf_q;
    rsp_sf_d     = rsp_sf_q;
    rsp_of_d     = rsp_of_q;
    cc_zf_d      = cc_zf_q;
    cc_sf_d      = cc_sf_q;
    cc_of_d      = cc_of_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      default:  if (rsp_ready && !accept) state_d = ST_EMPTY;
    endcase
    if (accept) begin
      last_grant_d = sel1;
      rsp_id_d     = sel1;
      rsp_result_d = alu_r;
      rsp_zf_d     = (alu_r == '0);
      rsp_sf_d     = alu_r[W-1];
      rsp_of_d     = alu_of;
      if (setcc) begin
        cc_zf_d = (alu_r == '0);
        cc_sf_d = alu_r[W-1];
        cc_of_d = alu_of;
      end
    end
  end

  // State registers with synchronous reset that discards any held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      last_grant_q <= 1'b1;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zf_q     <= 1'b0;
      rsp_sf_q     <= 1'b0;
      rsp_of_q     <= 1'b0;
      cc_zf_q      <= 1'b1;
      cc_sf_q      <= 1'b0;
      cc_of_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zf_q     <= rsp_zf_d;
      rsp_sf_q     <= rsp_sf_d;
      rsp_of_q     <= rsp_of_d;
      cc_zf_q      <= cc_zf_d;
      cc_sf_q      <= cc_sf_d;
      cc_of_q      <= cc_of_d;
    end
  end

  assign rsp_valid  = (state_q == ST_FULL);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zf     = rsp_zf_q;
  assign rsp_sf     = rsp_sf_q;
  assign rsp_of     = rsp_of_q;
  assign cc_zf      = cc_zf_q;
  assign cc_sf      = cc_sf_q;
  assign cc_of      = cc_of_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Testbench for alu_share_ctrl: scenario tasks with inline checks plus a
// negedge monitor that scoreboards every accepted op against delivered results.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_setcc;
  logic [1:0]  req0_op;
  logic [63:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_setcc;
  logic [1:0]  req1_op;
  logic [63:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [63:0] rsp_result;
  logic        rsp_zf, rsp_sf, rsp_of;
  logic        cc_zf, cc_sf, cc_of;

  int checks = 0;
  int failures = 0;

  // Scoreboard entry: {id, result, zf, sf, of}
  logic [67:0] exp_q[$];
  logic [67:0] sb_exp, sb_got;

  alu_share_ctrl #(.W(64)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_setcc(req0_setcc), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_setcc(req1_setcc), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zf(rsp_zf), .rsp_sf(rsp_sf), .rsp_of(rsp_of),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference ALU: {result, zf, sf, of}; overflow from a 65-bit signed result.
  function automatic logic [66:0] model(input logic [1:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    logic signed [64:0] wide;
    logic [63:0] r;
    logic of;
    wide = '0;
    of = 1'b0;
    case (op)
      2'b00: begin wide = $signed({a[63], a}) + $signed({b[63], b}); r = wide[63:0]; of = wide[64] ^ wide[63]; end
      2'b01: begin wide = $signed({a[63], a}) - $signed({b[63], b}); r = wide[63:0]; of = wide[64] ^ wide[63]; end
      2'b10: r = a & b;
      default: r = a ^ b;
    endcase
    return {r, (r == 64'd0), r[63], of};
  endfunction

  // Monitor: pop/compare on delivery, push model result on accept.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        checks++;
        sb_got = {rsp_id, rsp_result, rsp_zf, rsp_sf, rsp_of};
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected got=%h required=none", sb_got);
        end else begin
          sb_exp = exp_q.pop_front();
          if (sb_got !== sb_exp) begin
            failures++;
            $display("FAIL sb_data got=%h required=%h", sb_got, sb_exp);
          end
        end
      end
      if (req0_ready && req1_ready) begin
        checks++;
        failures++;
        $display("FAIL dual_grant got=11 required=one-hot");
      end
      if (req0_valid && req0_ready) exp_q.push_back({1'b0, model(req0_op, req0_a, req0_b)});
      if (req1_valid && req1_ready) exp_q.push_back({1'b1, model(req1_op, req1_a, req1_b)});
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [1:0] op, input logic sc,
                        input logic [63:0] a, input logic [63:0] b);
    req0_valid = v; req0_op = op; req0_setcc = sc; req0_a = a; req0_b = b;
  endtask

  task automatic drive1(input logic v, input logic [1:0] op, input logic sc,
                        input logic [63:0] a, input logic [63:0] b);
    req1_valid = v; req1_op = op; req1_setcc = sc; req1_a = a; req1_b = b;
  endtask

  task automatic idle_drain();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rsp_ready = 1'b1;
    drive0(1'b1, 2'b00, 1'b0, 64'd1, 64'd2);
    drive1(1'b1, 2'b00, 1'b0, 64'd3, 64'd4);
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b required=00", {req0_ready, req1_ready});
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_zf, rsp_sf, rsp_of} !== 69'd0) begin
      failures++; $display("FAIL reset_rsp got=%b/%b/%h required=0/0/0", rsp_valid, rsp_id, rsp_result);
    end
    checks++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
      failures++; $display("FAIL reset_cc got=%b required=100", {cc_zf, cc_sf, cc_of});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++; $display("FAIL first_grant got=%b required=10", {req0_ready, req1_ready});
    end
    tick();
    idle_drain();
  endtask

  task automatic test_sub_overflow();
    rsp_ready = 1'b0;
    drive0(1'b1, 2'b01, 1'b1, 64'h8000_0000_0000_0000, 64'd1);
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++; $display("FAIL sub_ready got=%b required=1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_id, rsp_result} !== {2'b10, 64'h7FFF_FFFF_FFFF_FFFF}) begin
      failures++; $display("FAIL sub_rsp got=%b/%b/%h required=1/0/7fffffffffffffff", rsp_valid, rsp_id, rsp_result);
    end
    checks++;
    if ({rsp_zf, rsp_sf, rsp_of, cc_zf, cc_sf, cc_of} !== 6'b001001) begin
      failures++; $display("FAIL sub_flags got=%b required=001001", {rsp_zf, rsp_sf, rsp_of, cc_zf, cc_sf, cc_of});
    end
    idle_drain();
  endtask

  task automatic test_add_wrap();
    rsp_ready = 1'b1;
    drive1(1'b1, 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      failures++; $display("FAIL add_ready got=%b required=01", {req0_ready, req1_ready});
    end
    tick();
    drive1(1'b1, 2'b11, 1'b0, 64'd5, 64'd5);
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_zf, rsp_sf, rsp_of} !== {2'b11, 64'd0, 3'b100}) begin
      failures++; $display("FAIL add_rsp got=%b/%b/%h/%b required=1/1/0/100", rsp_valid, rsp_id, rsp_result, {rsp_zf, rsp_sf, rsp_of});
    end
    checks++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
      failures++; $display("FAIL add_cc got=%b required=100", {cc_zf, cc_sf, cc_of});
    end
    tick();
    drive1(1'b1, 2'b10, 1'b0, 64'hF, 64'd1);
    checks++;
    if ({rsp_result, rsp_zf} !== {64'd0, 1'b1}) begin
      failures++; $display("FAIL xor_rsp got=%h/%b required=0/1", rsp_result, rsp_zf);
    end
    tick();
    req1_valid = 1'b0;
    checks++;
    if ({rsp_result, rsp_zf, cc_zf, cc_sf, cc_of} !== {64'd1, 1'b0, 3'b100}) begin
      failures++; $display("FAIL nosetcc got=%h/%b cc=%b required=1/0 cc=100", rsp_result, rsp_zf, {cc_zf, cc_sf, cc_of});
    end
    idle_drain();
  endtask

  task automatic test_round_robin();
    logic exp_id;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_id = i[0];
      drive0(1'b1, 2'($urandom_range(0, 3)), 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
      drive1(1'b1, 2'($urandom_range(0, 3)), 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== {~exp_id, exp_id}) begin
        failures++; $display("FAIL rr_grant i=%0d got=%b required=%b", i, {req0_ready, req1_ready}, {~exp_id, exp_id});
      end
      tick();
      checks++;
      if ({rsp_valid, rsp_id} !== {1'b1, exp_id}) begin
        failures++; $display("FAIL rr_id i=%0d got=%b/%b required=1/%b", i, rsp_valid, rsp_id, exp_id);
      end
    end
    idle_drain();
  endtask

  task automatic test_back_to_back();
    logic [66:0] m0, m1;
    rsp_ready = 1'b0;
    drive0(1'b1, 2'b00, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
    m0 = model(req0_op, req0_a, req0_b);
    tick();
    drive1(1'b1, 2'b01, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
    m1 = model(req1_op, req1_a, req1_b);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        failures++; $display("FAIL bp_ready i=%0d got=%b required=00", i, {req0_ready, req1_ready});
      end
      checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_zf, rsp_sf, rsp_of} !== {2'b10, m0}) begin
        failures++; $display("FAIL bp_hold i=%0d got=%h required=%h", i, {rsp_result, rsp_zf, rsp_sf, rsp_of}, m0);
      end
      tick();
    end
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release got=%b required=1", req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_zf, rsp_sf, rsp_of} !== {2'b11, m1}) begin
      failures++; $display("FAIL bp_next got=%b/%b/%h required=1/1/%h", rsp_valid, rsp_id, rsp_result, m1);
    end
    idle_drain();
  endtask

  task automatic test_mid_reset();
    rsp_ready = 1'b0;
    drive0(1'b1, 2'b10, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    req0_valid = 1'b0;
    checks++;
    if ({rsp_valid, cc_zf, cc_sf, cc_of} !== 4'b1010) begin
      failures++; $display("FAIL mr_held got=%b required=1010", {rsp_valid, cc_zf, cc_sf, cc_of});
    end
    rst = 1'b1;
    drive1(1'b1, 2'b00, 1'b1, 64'd7, 64'd9);
    #1;
    checks++;
    if (req1_ready !== 1'b0) begin
      failures++; $display("FAIL mr_ready got=%b required=0", req1_ready);
    end
    tick();
    rst = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    checks++;
    if ({rsp_valid, rsp_result, cc_zf, cc_sf, cc_of} !== {1'b0, 64'd0, 3'b100}) begin
      failures++; $display("FAIL mr_after got=%b/%h cc=%b required=0/0 cc=100", rsp_valid, rsp_result, {cc_zf, cc_sf, cc_of});
    end
    tick();
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++; $display("FAIL mr_delivered got=%b required=0", rsp_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    drive0(1'b0, 2'b00, 1'b0, 64'd0, 64'd0);
    drive1(1'b0, 2'b00, 1'b0, 64'd0, 64'd0);
    test_reset();
    test_sub_overflow();
    test_add_wrap();
    test_round_robin();
    test_back_to_back();
    test_mid_reset();
    idle_drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL sb_leftover got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
